// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One grant per cycle; read data returns to the granted port one cycle later.
module ram_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t        r_owner, w_owner_nxt;
    logic          r_last, w_last_nxt;
    logic [CW-1:0] r_burst_cnt, w_cnt_nxt, w_cnt_sat;
    logic          r_rd_tag0, r_rd_tag1;
    logic          w_g0, w_g1, w_gnt0, w_gnt1;
    logic          w_below_max;

    assign w_below_max = (r_burst_cnt < CW'(MAX_BURST));
    assign w_cnt_sat   = (r_burst_cnt == CW'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + CW'(1);

    // Owner keeps the RAM until it drops req or exhausts its burst while the other waits
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (r_owner == OWN_P0 && req0 && (w_below_max || !req1)) begin
            w_g0 = 1'b1;
        end else if (r_owner == OWN_P1 && req1 && (w_below_max || !req0)) begin
            w_g1 = 1'b1;
        end else if (req0 && !req1) begin
            w_g0 = 1'b1;
        end else if (req1 && !req0) begin
            w_g1 = 1'b1;
        end else if (req0 && req1) begin
            if (r_last) w_g0 = 1'b1;
            else        w_g1 = 1'b1;
        end
    end

    assign w_gnt0 = w_g0 & rst_n;
    assign w_gnt1 = w_g1 & rst_n;
    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;

    always_comb begin
        w_owner_nxt = OWN_NONE;
        w_cnt_nxt   = '0;
        w_last_nxt  = r_last;
        if (w_gnt0) begin
            w_last_nxt  = 1'b0;
            w_cnt_nxt   = (r_owner == OWN_P0) ? w_cnt_sat : CW'(1);
            w_owner_nxt = lock0 ? OWN_P0 : OWN_NONE;
        end else if (w_gnt1) begin
            w_last_nxt  = 1'b1;
            w_cnt_nxt   = (r_owner == OWN_P1) ? w_cnt_sat : CW'(1);
            w_owner_nxt = lock1 ? OWN_P1 : OWN_NONE;
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_gnt0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (w_gnt1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_din  = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_NONE;
            r_last      <= 1'b1;
            r_burst_cnt <= '0;
            r_rd_tag0   <= 1'b0;
            r_rd_tag1   <= 1'b0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_rd_tag0   <= w_gnt0 & ~we0;
            r_rd_tag1   <= w_gnt1 & ~we1;
        end
    end

    assign rvalid0 = r_rd_tag0;
    assign rvalid1 = r_rd_tag1;
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x8 RAM and a read-data scoreboard.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [7:0] rdata0, rdata1, ram_addr, ram_din, ram_dout;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } rd_t;

    rd_t        sb_q[$];
    logic [7:0] mem   [256];
    logic [7:0] shadow[256];
    logic       exp_rv0, exp_rv1;
    int         checks = 0;
    int         errors = 0;

    ram_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port sync RAM: registered read returns old contents on read-during-write
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input logic port, input logic [7:0] obs);
        rd_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("rd_port", 32'(port), 32'(e.port));
            chk("rd_data", 32'(obs), 32'(e.data));
        end
    endtask

    // Drive one cycle, check grant/mux/read return at negedge, then advance
    task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic l0, input logic r1, input logic w1, input logic [7:0] a1,
                        input logic [7:0] d1, input logic l1, input logic eg0, input logic eg1);
        logic       xwe;
        logic [7:0] xad, xdi;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        @(negedge clk);
        xwe = 1'b0; xad = 8'h00; xdi = 8'h00;
        if (eg0) begin xwe = w0; xad = a0; xdi = d0; end
        else if (eg1) begin xwe = w1; xad = a1; xdi = d1; end
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("ram_we", 32'(ram_we), 32'(xwe));
        chk("ram_addr", 32'(ram_addr), 32'(xad));
        chk("ram_din", 32'(ram_din), 32'(xdi));
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
        if (rvalid0) pop_chk(1'b0, rdata0);
        if (rvalid1) pop_chk(1'b1, rdata1);
        if (eg0 && !w0) sb_q.push_back('{port: 1'b0, data: shadow[a0]});
        if (eg0 && w0)  shadow[a0] = d0;
        if (eg1 && !w1) sb_q.push_back('{port: 1'b1, data: shadow[a1]});
        if (eg1 && w1)  shadow[a1] = d1;
        exp_rv0 = eg0 & ~w0;
        exp_rv1 = eg1 & ~w1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic erv_dummy);
        step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, erv_dummy);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        // Reset with active requests: everything must stay quiet
        rst_n = 1'b0;
        req0 = 1; we0 = 1; addr0 = 8'h33; wdata0 = 8'h77; lock0 = 1;
        req1 = 1; we1 = 0; addr1 = 8'h44; wdata1 = 8'h00; lock1 = 0;
        #12;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        @(posedge clk); #1;
        req0 = 0; req1 = 0; lock0 = 0;
        rst_n = 1'b1;

        // Write then read back on port 0
        step(1, 1, 8'h00, 8'hD2, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        step(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h01, 8'h3C, 0, 0, 1);

        // Both reading, no lock: strict alternation
        step(1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        step(1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);

        // Locked burst with port 1 waiting: four grants to 0, one to 1, back to 0
        step(1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 8'h01, 8'h00, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 0, 8'h00, 8'h00, 1, 1, 0, 8'h01, 8'h00, 0, 0, 1);
        step(1, 0, 8'h00, 8'h00, 1, 1, 0, 8'h01, 8'h00, 0, 1, 0);

        // Locked burst, port 1 idle: no preemption; counter saturates then preempts at once
        for (int i = 0; i < 6; i++)
            step(1, 0, 8'(i), 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        idle(0);

        // Port 1 write immediately followed by port 0 read of the same address
        step(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h2D, 8'hAC, 0, 0, 1);
        step(1, 0, 8'h2D, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        idle(0);

        // Reset during a granted write must suppress it and drop the pending rvalid
        step(1, 1, 8'h10, 8'h55, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h99; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = 8'h00; wdata1 = 8'h00; lock1 = 0;
        #1;
        chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
        chk("pre_rst_ram_we", 32'(ram_we), 32'd1);
        chk("pre_rst_rvalid0", 32'(rvalid0), 32'd1);
        if (rvalid0) pop_chk(1'b0, rdata0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt0", 32'(gnt0), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_ram_din", 32'(ram_din), 32'd0);
        chk("mid_rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("mid_rst_rvalid1", 32'(rvalid1), 32'd0);
        @(posedge clk); #1;
        req0 = 0; we0 = 0;
        rst_n = 1'b1;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;

        // After reset port 0 wins the first tie; the suppressed write left 0x55 in place
        step(1, 0, 8'h10, 8'h00, 0, 1, 0, 8'h2D, 8'h00, 0, 1, 0);
        step(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h2D, 8'h00, 0, 0, 1);
        idle(0);
        idle(0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter placed in front of the 256x8 single-port synchronous RAM, so two independent requesters can share it. Each cycle it grants at most one port and muxes that port's write-enable, address and write data onto the RAM. It returns read data to the originating port one cycle later. A per-port lock input allows bounded back-to-back bursts without starving the other port.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- MAX_BURST, 4, max consecutive locked grants to one port while the other waits (>=1)

Ports (N = 0, 1):
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- reqN  in  1  port N requests an access this cycle
- weN  in  1  1 = write, 0 = read; valid with reqN
- addrN  in  AW  access address
- wdataN  in  DW  write data
- lockN  in  1  keep ownership after this grant (burst)
- gntN  out  1  combinational; access accepted this cycle
- rvalidN  out  1  registered; rdataN valid (read granted previous cycle)
- rdataN  out  DW  read data, equals ram_dout
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM registered read data (updated each posedge; read-during-write returns old contents)

## Operation
- State registers: owner (NONE/P0/P1), last (port served most recently, reset = 1 so port 0 wins the first tie), burst_cnt (consecutive grants to the current owner, width clog2(MAX_BURST+1)), rd_tag0/rd_tag1.
- Grant decision each cycle, evaluated in this order:
  - Owner O is set and reqO=1 and (burst_cnt < MAX_BURST or other port idle): grant O.
  - Otherwise, exactly one req: grant that port.
  - Otherwise, both req: grant port != last.
  - Otherwise: no grant.
- gnt0 and gnt1 are never both 1. Both are forced to 0 while rst_n=0.
- RAM mux:
  - Granted port drives ram_we=weN, ram_addr=addrN, ram_din=wdataN.
  - No grant: ram_we=0, ram_addr=0, ram_din=0.
- On a grant to port G at posedge:
  - last <= G.
  - If G == owner, burst_cnt <= burst_cnt+1 (saturate at MAX_BURST); else burst_cnt <= 1.
  - owner <= lockG ? G : NONE.
- On no grant: owner <= NONE, burst_cnt <= 0.
- Owner drops reqO: ownership is lost that cycle and normal round-robin applies.
- Preemption at MAX_BURST grants hands the RAM to the waiting port. The preempted port may regain it afterwards via round-robin.
- Read return:
  - rd_tagN <= gntN & ~weN.
  - rvalidN = rd_tagN.
  - rdataN = ram_dout (both ports see it; only the port with rvalid set consumes it).
- Requester rule: hold reqN/weN/addrN/wdataN stable until gntN=1. The arbiter does not queue requests.

## Timing
- Reset values:
  - owner=NONE, last=1, burst_cnt=0, rd_tag0=rd_tag1=0.
  - Outputs: gnt=0, rvalid=0, ram_we=0, ram_addr=0, ram_din=0.
  - rdataN follows ram_dout and is don't-care while rvalidN=0.
- Grant latency: 0 cycles (same cycle as req when the arbiter is free).
- Write: committed at the posedge ending the grant cycle.
- Read latency: grant in cycle T, rvalidN=1 with data in cycle T+1. Back-to-back reads give one rvalid per cycle.
- Write then read of the same address in consecutive grants returns the new data. Read and write in the same cycle is impossible (one grant per cycle).
- Worst-case wait for a requesting port: MAX_BURST cycles.
- Reset mid-operation:
  - Asserting rst_n low immediately clears all state.
  - A pending rvalid is dropped and the write in progress is suppressed (ram_we forced 0).

## Test plan
- Reset, then req0=1 we0=1 addr0=0x00 wdata0=0xD2 for 1 cycle; then req0 read addr 0x00 -> gnt0 same cycle, rvalid0=1 next cycle with rdata0=0xD2, rvalid1=0.
- Both ports read continuously, lock=0 -> grants alternate 0,1,0,1...; rvalid alternates one cycle behind.
- Port 0 lock=1 with continuous req, port 1 req constant, MAX_BURST=4 -> gnt0 for 4 cycles, then gnt1 for 1 cycle, then gnt0 again.
- Port 0 locked burst, port 1 idle -> gnt0 every cycle indefinitely, burst_cnt saturates at 4, no preemption.
- Port 1 writes 0xAC at 0x2D, port 0 reads 0x2D in the very next cycle -> rdata0=0xAC with rvalid0.
- Assert rst_n low during a granted write to 0x10 (prior value 0x55) -> ram_we=0 immediately, all outputs 0. A later read of 0x10 returns 0x55.
